// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - MIPS opcode/funct constants, request op codes and error codes
package mips_defs;

    localparam logic [5:0] OPC_SPECIAL = 6'b000000;
    localparam logic [5:0] OPC_REGIMM  = 6'b000001;
    localparam logic [5:0] OPC_JAL     = 6'b000011;
    localparam logic [5:0] OPC_BEQ     = 6'b000100;
    localparam logic [5:0] OPC_ORI     = 6'b001101;
    localparam logic [5:0] OPC_LUI     = 6'b001111;
    localparam logic [5:0] OPC_LW      = 6'b100011;
    localparam logic [5:0] OPC_SW      = 6'b101011;

    localparam logic [5:0] FUNCT_JR    = 6'b001000;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100011;

    localparam logic [4:0] RT_BGEZ     = 5'b00001;

    typedef enum logic [3:0] {
        OP_ADDU = 4'd0,
        OP_SUBU = 4'd1,
        OP_JR   = 4'd2,
        OP_ORI  = 4'd3,
        OP_LW   = 4'd4,
        OP_SW   = 4'd5,
        OP_BEQ  = 4'd6,
        OP_BGEZ = 4'd7,
        OP_LUI  = 4'd8,
        OP_JAL  = 4'd9
    } op_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_ALIGN   = 2'd2;
    localparam logic [1:0] ERR_RANGE   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

endpackage

// File: rtl/instr_encode_comb.sv
// rtl/instr_encode_comb.sv - combinational op-to-MIPS-word encoder with request validation
module instr_encode_comb
    import mips_defs::*;
(
    input  logic [3:0]  i_op,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [15:0] i_imm,
    input  logic [31:0] i_target,
    input  logic [31:0] i_pc,
    output logic [31:0] o_word,
    output logic [1:0]  o_err_code
);

    logic [31:0]        w_pc4;
    logic signed [32:0] w_diff;
    logic signed [32:0] w_off;
    logic               w_misaligned;
    logic               w_br_in_range;
    logic               w_jal_in_region;

    always_comb begin
        w_pc4           = i_pc + 32'd4;
        // Addresses are unsigned; widen by one bit so the difference keeps its sign.
        w_diff          = $signed({1'b0, i_target}) - $signed({1'b0, w_pc4});
        w_off           = w_diff >>> 2;
        w_misaligned    = |i_target[1:0];
        w_br_in_range   = (&w_off[32:15]) | ~(|w_off[32:15]);
        w_jal_in_region = (i_target[31:28] == w_pc4[31:28]);
    end

    always_comb begin
        o_word     = '0;
        o_err_code = ERR_NONE;
        case (i_op)
            OP_ADDU: o_word = {OPC_SPECIAL, i_rs, i_rt, i_rd, 5'b00000, FUNCT_ADDU};
            OP_SUBU: o_word = {OPC_SPECIAL, i_rs, i_rt, i_rd, 5'b00000, FUNCT_SUBU};
            OP_JR:   o_word = {OPC_SPECIAL, i_rs, 15'd0, FUNCT_JR};
            OP_ORI:  o_word = {OPC_ORI, i_rs, i_rt, i_imm};
            OP_LW:   o_word = {OPC_LW,  i_rs, i_rt, i_imm};
            OP_SW:   o_word = {OPC_SW,  i_rs, i_rt, i_imm};
            OP_LUI:  o_word = {OPC_LUI, 5'b00000, i_rt, i_imm};
            OP_BEQ, OP_BGEZ: begin
                o_word = (i_op == OP_BEQ) ? {OPC_BEQ, i_rs, i_rt, w_off[15:0]}
                                          : {OPC_REGIMM, i_rs, RT_BGEZ, w_off[15:0]};
                if (w_misaligned)
                    o_err_code = ERR_ALIGN;
                else if (!w_br_in_range)
                    o_err_code = ERR_RANGE;
            end
            OP_JAL: begin
                o_word = {OPC_JAL, i_target[27:2]};
                if (w_misaligned)
                    o_err_code = ERR_ALIGN;
                else if (!w_jal_in_region)
                    o_err_code = ERR_RANGE;
            end
            default: o_err_code = ERR_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - sequential MIPS program loader writing encoded words into IM
module instr_encoder
    import mips_defs::*;
#(
    parameter int          ADDR_W    = 5,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [31:0]       in_target,
    output logic              im_we,
    input  logic              im_ready,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              full,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(2**ADDR_W);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [ADDR_W:0]     r_ptr;
    logic [ADDR_W:0]     r_count;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [1:0]          r_err_code;

    logic [31:0]         w_pc;
    logic [31:0]         w_word;
    logic [1:0]          w_enc_err;
    logic                w_ready;
    logic                w_accept;
    logic                w_good;
    logic                w_bad;
    logic                w_commit;

    // r_ptr counts accepted good words, so it is the slot the next request occupies.
    assign w_pc = BASE_ADDR + {{(30-ADDR_W){1'b0}}, r_ptr[ADDR_W-1:0], 2'b00};

    instr_encode_comb u_encode (
        .i_op       (in_op),
        .i_rs       (in_rs),
        .i_rt       (in_rt),
        .i_rd       (in_rd),
        .i_imm      (in_imm),
        .i_target   (in_target),
        .i_pc       (w_pc),
        .o_word     (w_word),
        .o_err_code (w_enc_err)
    );

    // start takes priority, so a request presented alongside it is never accepted.
    assign w_ready  = (r_state == ST_RUN) & ~start & (~r_we | im_ready) & (r_ptr < CAP);
    assign w_accept = in_valid & w_ready;
    assign w_good   = w_accept & (w_enc_err == ERR_NONE);
    assign w_bad    = w_accept & (w_enc_err != ERR_NONE);
    assign w_commit = r_we & im_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_bad)
                        w_state_nxt = ST_ERR;
                    else if (w_commit && (r_count + 1'b1 == CAP))
                        w_state_nxt = ST_FULL;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_count    <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_err_code <= ERR_NONE;
        end else if (start) begin
            r_ptr      <= '0;
            r_count    <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_err_code <= ERR_NONE;
        end else begin
            if (w_bad)
                r_err_code <= w_enc_err;
            if (w_commit)
                r_count <= r_count + 1'b1;
            if (w_good) begin
                r_ptr   <= r_ptr + 1'b1;
                r_we    <= 1'b1;
                r_addr  <= r_ptr[ADDR_W-1:0];
                r_wdata <= w_word;
            end else if (w_commit) begin
                r_we    <= 1'b0;
            end
        end
    end

    assign in_ready = w_ready;
    assign im_we    = r_we;
    assign im_addr  = r_addr;
    assign im_wdata = r_wdata;
    assign count    = r_count;
    assign busy     = (r_state == ST_RUN);
    assign full     = (r_state == ST_FULL);
    assign err      = (r_state == ST_ERR);
    assign err_code = r_err_code;

endmodule
